// File: rtl/btb_pkg.sv
// btb_pkg -- shared constants and types for the 2-way set-associative BTB.
//   PC_W / TARGET_W / MAX_CTR_W : entry field widths
//   PC_INC                      : fall-through increment for not-taken predictions
//   weak_taken()                : counter init value (MSB set, rest clear)
//   upd_op_e                    : action chosen for a resolved-branch update
//   way_sel_t                   : tag-compare result (hit flag + matching way)
package btb_pkg;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned TARGET_W  = 32;
  localparam int unsigned MAX_CTR_W = 4;

  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_HIT,
    UPD_ALLOC
  } upd_op_e;

  typedef struct packed {
    logic hit;
    logic way;
  } way_sel_t;

  // Weakly-taken encoding for a counter of the given width.
  function automatic logic [MAX_CTR_W-1:0] weak_taken(input int unsigned bits);
    return MAX_CTR_W'(1) << (bits - 1);
  endfunction

endpackage

// File: rtl/btb_assoc_sat_ctr.sv
// sat_ctr -- combinational saturating up/down counter step.
//   value : current counter value
//   inc   : step up (held at all-ones)
//   dec   : step down (held at zero)
//   next  : resulting value; unchanged when neither or both are asserted
module sat_ctr #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] value,
  input  logic                inc,
  input  logic                dec,
  output logic [CTR_BITS-1:0] next
);

  always_comb begin
    next = value;
    if (inc && !dec && (value != '1)) begin
      next = value + CTR_BITS'(1);
    end else if (dec && !inc && (value != '0)) begin
      next = value - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// btb_assoc -- 2-way set-associative branch target buffer with per-entry
// saturating counters and one LRU bit per set.
//   clk, reset   : clock; synchronous active-high reset clearing all state
//   lookup_pc    : fetch PC, predicted combinationally from registered state
//   pred_pc      : target on a taken prediction, else lookup_pc + 4
//   pred_taken   : matching valid way with counter MSB set
//   upd_valid    : a branch/jump resolved this cycle
//   upd_pc       : PC of the resolved instruction
//   upd_target   : resolved target
//   upd_taken    : actual outcome
// Optional (macro BTB_ASSOC_PERF_EN):
//   perf_upd, perf_hit, perf_alloc : wrapping counts of update cycles,
//   update hits and allocations; cleared by reset.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int unsigned NUM_SETS = 32,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_W-1:0]     lookup_pc,
  output logic [PC_W-1:0]     pred_pc,
  output logic                pred_taken,
  input  logic                upd_valid,
  input  logic [PC_W-1:0]     upd_pc,
  input  logic [TARGET_W-1:0] upd_target,
  input  logic                upd_taken
`ifdef BTB_ASSOC_PERF_EN
  ,
  output logic [31:0]         perf_upd,
  output logic [31:0]         perf_hit,
  output logic [31:0]         perf_alloc
`endif
);

  localparam int unsigned IDX   = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = PC_W - 2 - IDX;

  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(weak_taken(CTR_BITS));

  // Entry storage, one array element per way.
  logic [NUM_SETS-1:0] valid_q  [2];
  logic [TAG_W-1:0]    tag_q    [2][NUM_SETS];
  logic [CTR_BITS-1:0] ctr_q    [2][NUM_SETS];
  logic [TARGET_W-1:0] target_q [2][NUM_SETS];
  // Points at the way to replace next in each set.
  logic [NUM_SETS-1:0] lru_q;

  // PC word-offset bits never participate in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------- lookup
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  way_sel_t         lk_sel;
  logic             lk_match0;
  logic             lk_match1;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = lookup_pc[PC_W-1:IDX+2];

  always_comb begin
    lk_match0  = valid_q[0][lk_idx] && (tag_q[0][lk_idx] == lk_tag);
    lk_match1  = valid_q[1][lk_idx] && (tag_q[1][lk_idx] == lk_tag);
    lk_sel.hit = lk_match0 || lk_match1;
    lk_sel.way = !lk_match0;
  end

  always_comb begin
    pred_taken = lk_sel.hit && ctr_q[lk_sel.way][lk_idx][CTR_BITS-1];
    pred_pc    = lookup_pc + PC_INC;
    if (pred_taken) begin
      pred_pc = target_q[lk_sel.way][lk_idx];
    end
  end

  // ---------------------------------------------------------------- update
  logic [IDX-1:0]      up_idx;
  logic [TAG_W-1:0]    up_tag;
  way_sel_t            up_sel;
  logic                up_match0;
  logic                up_match1;
  logic                alloc_way;
  logic                wr_way;
  upd_op_e             up_op;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_next;

  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[PC_W-1:IDX+2];

  always_comb begin
    up_match0  = valid_q[0][up_idx] && (tag_q[0][up_idx] == up_tag);
    up_match1  = valid_q[1][up_idx] && (tag_q[1][up_idx] == up_tag);
    up_sel.hit = up_match0 || up_match1;
    up_sel.way = !up_match0;
  end

  // Victim choice: invalid way 0, then invalid way 1, then the LRU way.
  always_comb begin
    if (!valid_q[0][up_idx]) begin
      alloc_way = 1'b0;
    end else if (!valid_q[1][up_idx]) begin
      alloc_way = 1'b1;
    end else begin
      alloc_way = lru_q[up_idx];
    end
  end

  always_comb begin
    up_op  = UPD_NONE;
    wr_way = up_sel.way;
    if (upd_valid) begin
      if (up_sel.hit) begin
        up_op = UPD_HIT;
      end else if (upd_taken) begin
        up_op  = UPD_ALLOC;
        wr_way = alloc_way;
      end
    end
  end

  assign ctr_cur = ctr_q[up_sel.way][up_idx];

  sat_ctr #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_ctr (
    .value (ctr_cur),
    .inc   (upd_taken),
    .dec   (~upd_taken),
    .next  (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '{default: '0};
      tag_q    <= '{default: '{default: '0}};
      ctr_q    <= '{default: '{default: '0}};
      target_q <= '{default: '{default: '0}};
      lru_q    <= '0;
    end else begin
      case (up_op)
        UPD_HIT: begin
          ctr_q[wr_way][up_idx] <= ctr_next;
          if (upd_taken) begin
            target_q[wr_way][up_idx] <= upd_target;
          end
          lru_q[up_idx] <= ~wr_way;
        end
        UPD_ALLOC: begin
          valid_q[wr_way][up_idx]  <= 1'b1;
          tag_q[wr_way][up_idx]    <= up_tag;
          ctr_q[wr_way][up_idx]    <= CTR_INIT;
          target_q[wr_way][up_idx] <= upd_target;
          lru_q[up_idx]            <= ~wr_way;
        end
        default: ;
      endcase
    end
  end

`ifdef BTB_ASSOC_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_upd   <= '0;
      perf_hit   <= '0;
      perf_alloc <= '0;
    end else begin
      if (upd_valid) begin
        perf_upd <= perf_upd + 32'd1;
      end
      if (up_op == UPD_HIT) begin
        perf_hit <= perf_hit + 32'd1;
      end
      if (up_op == UPD_ALLOC) begin
        perf_alloc <= perf_alloc + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL provide parameter NUM_SETS, default 32, number of sets; power of two, 4..256.
REQ-002 SHALL provide parameter CTR_BITS, default 2, saturating-counter width; 2..4.
REQ-003 SHALL have these ports: clk input 1, clock; reset input 1, synchronous, active-high.
REQ-004 SHALL have lookup_pc input 32, fetch PC.
REQ-005 SHALL have pred_pc output 32, predicted next PC.
REQ-006 SHALL have pred_taken output 1, prediction is taken.
REQ-007 SHALL have upd_valid input 1, resolved branch/jump this cycle.
REQ-008 SHALL have upd_pc input 32, PC of the resolved instruction.
REQ-009 SHALL have upd_target input 32, resolved target.
REQ-010 SHALL have upd_taken input 1, actual outcome.

Function
REQ-011 SHALL be organised as 2 ways x NUM_SETS, each entry: valid, tag, CTR_BITS counter, 32-bit target; plus 1 LRU bit per set.
REQ-012 SHALL use index = pc[IDX+1:2] and tag = pc[31:IDX+2], where IDX = log2(NUM_SETS).
REQ-013 SHALL compute the lookup combinationally, with zero latency, from registered state only; there SHALL be no same-cycle update bypass.
REQ-014 SHALL drive pred_taken=1 and pred_pc=target when a valid way tag-matches and its counter MSB=1; otherwise pred_taken=0 and pred_pc=lookup_pc+4, with 32-bit wrap.
REQ-015 On upd_valid with a hit, SHALL increment the counter when taken and decrement it when not taken, saturating at all-ones and zero.
REQ-016 On an update hit with upd_taken=1, SHALL overwrite the target with upd_target; a not-taken hit SHALL leave the target unchanged.
REQ-017 On an update miss with upd_taken=1, SHALL allocate an entry: invalid way 0 first, else invalid way 1, else the LRU way. The new entry gets valid=1, the tag, the target, and the counter at weakly-taken (MSB=1, rest 0).
REQ-018 On an update miss with upd_taken=0, SHALL allocate nothing and change no state.
REQ-019 SHALL set the set's LRU bit to point at the other way after every update hit or allocation; lookups SHALL NOT touch LRU.
REQ-020 SHALL never create two valid ways with the same tag in one set.
REQ-021 SHALL commit all updates on the rising clk edge; a same-cycle lookup of the updated set SHALL see the old state.

Reset
REQ-022 On reset, SHALL clear every valid bit, counter, target and LRU bit to 0 within one clk edge; reset SHALL override a concurrent upd_valid.
REQ-023 During and after reset, until the first allocation, SHALL output pred_taken=0 and pred_pc=lookup_pc+4.
REQ-024 A reset asserted mid-operation SHALL discard all learned state; there SHALL be no partial retention.

Configuration
REQ-025 With macro BTB_ASSOC_PERF_EN defined, SHALL add 32-bit outputs perf_upd, perf_hit and perf_alloc. These count upd_valid cycles, update hits and allocations, wrap at 2^32, and clear on reset.
REQ-026 Without BTB_ASSOC_PERF_EN, the perf ports and counters SHALL be absent and function SHALL be otherwise identical.

Structure
REQ-027 SHALL place the counter init constant (weakly-taken), the PC+4 increment constant and the entry field widths in the shared package btb_pkg.
REQ-028 SHALL implement the saturating counter as sub-module sat_ctr, parameterised by CTR_BITS, inputs inc/dec, output next value.

Verification
REQ-029 After reset with lookup_pc=0x0000_0100, SHALL give pred_taken=0 and pred_pc=0x0000_0104.
REQ-030 A taken update for upd_pc=0x100 to target 0x200, followed by a lookup of 0x100, SHALL give pred_taken=1 and pred_pc=0x200.
REQ-031 Two not-taken updates to 0x100 (counter 10->01->00) SHALL give pred_taken=0, and three further taken updates SHALL saturate the counter at 11.
REQ-032 Taken updates to 0x100, 0x180 and 0x200 (same set, NUM_SETS=32) SHALL evict 0x100, after which 0x180 and 0x200 hit and 0x100 misses.
REQ-033 An update of 0x100 with a simultaneous lookup of 0x100 SHALL give an old-state prediction in the same cycle and the new prediction in the next cycle.
REQ-034 With BTB_ASSOC_PERF_EN, after REQ-032 SHALL read perf_upd=3, perf_hit=0, perf_alloc=3, and reset SHALL clear all three to 0.
